// File: rtl/shift_pkg.sv
// Shared constants for the shifter arbiter: widths, shift op codes and FSM encoding.
package shift_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  typedef logic [1:0] shop_t;

  localparam shop_t SHOP_SRL = 2'b00;
  localparam shop_t SHOP_SRA = 2'b01;
  localparam shop_t SHOP_SLL = 2'b10;
  localparam shop_t SHOP_ILL = 2'b11;

  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_RESP = 1'b1;

endpackage

// File: rtl/shifter_arbiter_if.sv
// Request/response bundle between the two shift clients and the arbiter.
// valid/ready: a transfer happens on a rising edge where both are high; the
// sender holds its payload stable while valid is high and ready is low.
interface shifter_arbiter_if;
  import shift_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_in;
  logic [1:0]        req0_op;
  logic [AMT_W-1:0]  req0_amt;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_in;
  logic [1:0]        req1_op;
  logic [AMT_W-1:0]  req1_amt;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req0_valid, req0_in, req0_op, req0_amt,
    output req1_valid, req1_in, req1_op, req1_amt,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data, resp_err,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_in, req0_op, req0_amt,
    input  req1_valid, req1_in, req1_op, req1_amt,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data, resp_err,
    input  resp_ready
  );

endinterface

// File: rtl/Shifter.sv
// Combinational barrel shifter: logical right, arithmetic right, logical left.
module Shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        op_i,
  input  logic [AMT_W-1:0]  amt_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (op_i)
      SHOP_SRL: data_o = data_i >> amt_i;
      SHOP_SRA: data_o = DATA_W'($signed(data_i) >>> amt_i);
      SHOP_SLL: data_o = data_i << amt_i;
      default:  data_o = data_i;
    endcase
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Two-client arbiter in front of the shared Shifter with a registered result.
// SHIFT_ARB_RR_EN selects round-robin tie-break; undefined gives fixed priority to requester 0.
module shifter_arbiter
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  shifter_arbiter_if.slave bus,
  output logic [0:0]       dbg_state_o
);

  logic [0:0]        state_q, state_d;
  logic              id_q;
  logic              err_q;
  logic [DATA_W-1:0] in_q;
  logic [1:0]        op_q;
  logic [AMT_W-1:0]  amt_q;

  logic              gnt;
  logic              slot_free;
  logic              accept;
  logic [DATA_W-1:0] sel_in;
  logic [1:0]        sel_op;
  logic [AMT_W-1:0]  sel_amt;
  logic              sel_ill;
  logic [DATA_W-1:0] sh_out;

`ifdef SHIFT_ARB_RR_EN
  logic last_q;

  always_comb gnt = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n)      last_q <= 1'b1;
    else if (accept) last_q <= gnt;
  end
`else
  always_comb gnt = bus.req1_valid && !bus.req0_valid;
`endif

  // The slot frees in the same cycle the held result is taken, giving one op per cycle.
  assign slot_free      = (state_q == ARB_IDLE) || bus.resp_ready;
  assign bus.req0_ready = bus.req0_valid && !gnt && slot_free;
  assign bus.req1_ready = bus.req1_valid &&  gnt && slot_free;
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign sel_in  = gnt ? bus.req1_in  : bus.req0_in;
  assign sel_op  = gnt ? bus.req1_op  : bus.req0_op;
  assign sel_amt = gnt ? bus.req1_amt : bus.req0_amt;
  assign sel_ill = (sel_op == SHOP_ILL);

  always_comb begin
    state_d = state_q;
    if (accept)                                      state_d = ARB_RESP;
    else if (state_q == ARB_RESP && bus.resp_ready)  state_d = ARB_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      in_q    <= '0;
      op_q    <= SHOP_SRL;
      amt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        in_q  <= sel_in;
        op_q  <= sel_ill ? SHOP_SRL : sel_op;
        amt_q <= sel_ill ? '0 : sel_amt;
        err_q <= sel_ill;
        id_q  <= gnt;
      end
    end
  end

  Shifter u_shifter (
    .data_i (in_q),
    .op_i   (op_q),
    .amt_i  (amt_q),
    .data_o (sh_out)
  );

  assign bus.resp_valid = (state_q == ARB_RESP);
  assign bus.resp_data  = sh_out;
  assign bus.resp_id    = id_q;
  assign bus.resp_err   = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: single ops, contention, backpressure, illegal op, mid-op reset.
module tb_shifter_arbiter;
  import shift_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [0:0] dbg_state;
  int         total;
  int         bad;

  shifter_arbiter_if bus ();

  shifter_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_in = '0; bus.req0_op = 2'b00; bus.req0_amt = '0;
    bus.req1_valid = 1'b0; bus.req1_in = '0; bus.req1_op = 2'b00; bus.req1_amt = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Presents one request from an idle arbiter and lets it be accepted on the next edge.
  task automatic issue(input bit n, input logic [31:0] d, input logic [1:0] op, input logic [4:0] amt);
    if (!n) begin
      bus.req0_in = d; bus.req0_op = op; bus.req0_amt = amt; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_in = d; bus.req1_op = op; bus.req1_amt = amt; bus.req1_valid = 1'b1;
    end
    #2;
    chk("issue_ready", {31'd0, n ? bus.req1_ready : bus.req0_ready}, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] d, input logic id, input logic err);
    chk({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, "_data"},  bus.resp_data, d);
    chk({tag, "_id"},    {31'd0, bus.resp_id}, {31'd0, id});
    chk({tag, "_err"},   {31'd0, bus.resp_err}, {31'd0, err});
  endtask

  task automatic drain(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    chk({tag, "_drained"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  logic        exp_ids [4];
  logic [31:0] held_data;
  logic        held_id;

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    do_reset();

    chk("rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_id",    {31'd0, bus.resp_id},    32'd0);
    chk("rst_data",  bus.resp_data,           32'd0);
    chk("rst_err",   {31'd0, bus.resp_err},   32'd0);
    chk("rst_state", {31'd0, dbg_state},      {31'd0, ARB_IDLE});

    issue(1'b0, 32'h0000_0001, 2'b10, 5'd3);
    check_resp("sll", 32'h0000_0008, 1'b0, 1'b0);
    chk("sll_state", {31'd0, dbg_state}, {31'd0, ARB_RESP});
    drain("sll");

    issue(1'b1, 32'h8000_0000, 2'b01, 5'd4);
    check_resp("sra", 32'hF800_0000, 1'b1, 1'b0);
    drain("sra");

    issue(1'b1, 32'h8000_0000, 2'b00, 5'd4);
    check_resp("srl", 32'h0800_0000, 1'b1, 1'b0);
    drain("srl");

    issue(1'b0, 32'h8000_0000, 2'b01, 5'd0);
    check_resp("amt0", 32'h8000_0000, 1'b0, 1'b0);
    drain("amt0");

    issue(1'b0, 32'h1234_5678, 2'b11, 5'd7);
    check_resp("ill", 32'h1234_5678, 1'b0, 1'b1);
    drain("ill");

    // Contention from reset: req0 yields 0x2, req1 yields 0x10.
`ifdef SHIFT_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    bus.req0_in = 32'h0000_0001; bus.req0_op = 2'b10; bus.req0_amt = 5'd1;
    bus.req1_in = 32'h0000_0100; bus.req1_op = 2'b00; bus.req1_amt = 5'd4;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("tie_ready0", {31'd0, bus.req0_ready}, {31'd0, ~exp_ids[i]});
      chk("tie_ready1", {31'd0, bus.req1_ready}, {31'd0, exp_ids[i]});
      tick();
      check_resp("tie", exp_ids[i] ? 32'h0000_0010 : 32'h0000_0002, exp_ids[i], 1'b0);
    end

    bus.resp_ready = 1'b0;
    held_id   = exp_ids[3];
    held_data = held_id ? 32'h0000_0010 : 32'h0000_0002;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("bp_ready0", {31'd0, bus.req0_ready}, 32'd0);
      chk("bp_ready1", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      check_resp("bp_hold", held_data, held_id, 1'b0);
    end
    bus.resp_ready = 1'b1;
    #2;
    chk("bp_release_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("bp_release_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    check_resp("bp_next", 32'h0000_0002, 1'b0, 1'b0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    drain("bp");

    // Mid-operation reset: the held result from req0 must vanish and the tie go to req0.
    issue(1'b0, 32'h0000_00F0, 2'b00, 5'd4);
    bus.resp_ready = 1'b0;
    check_resp("mid", 32'h0000_000F, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("midrst_data",  bus.resp_data,           32'd0);
    chk("midrst_state", {31'd0, dbg_state},      {31'd0, ARB_IDLE});
    bus.resp_ready = 1'b1;
    bus.req0_in = 32'h0000_0003; bus.req0_op = 2'b10; bus.req0_amt = 5'd2;
    bus.req1_in = 32'h0000_0040; bus.req1_op = 2'b00; bus.req1_amt = 5'd2;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #2;
    chk("midrst_tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
    chk("midrst_tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_resp("midrst_tie", 32'h0000_000C, 1'b0, 1'b0);
    drain("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
